// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one uart transmitter among NREQ
// requesters. One byte is in flight at a time. The arbiter launches it, waits
// for the uart to start and finish, then reports per-requester completion.
module uart_tx_arbiter #(
    parameter int NREQ          = 2,
    parameter int START_TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req,
    input  logic [8*NREQ-1:0]   req_byte,
    output logic [NREQ-1:0]     gnt,
    output logic [NREQ-1:0]     done,
    output logic                err,
    output logic                busy,
    output logic                uart_transmit,
    output logic [7:0]          uart_tx_byte,
    input  logic                uart_is_transmitting
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNT_W = $clog2(START_TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT_START,
        WAIT_END
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   last;
    logic [CNT_W-1:0]   count;
    logic               win_found;
    logic [IDX_W-1:0]   win_idx;
    logic [7:0]         win_byte;

    // Pick the first pending requester after the last winner, wrapping around,
    // so nobody is granted twice while another requester is waiting.
    always_comb begin : pick_winner
        logic [IDX_W-1:0] cand;
        win_found = 1'b0;
        win_idx   = last;
        cand      = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IDX_W'((int'(last) + k) % NREQ);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
        win_byte = req_byte[{win_idx, 3'b000} +: 8];
    end

    // Arbitration / launch / completion FSM; every output is a register here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            gnt           <= '0;
            done          <= '0;
            err           <= 1'b0;
            busy          <= 1'b0;
            uart_transmit <= 1'b0;
            uart_tx_byte  <= 8'h00;
            last          <= IDX_W'(NREQ - 1);
            count         <= '0;
        end else begin
            // gnt, done, err and uart_transmit are single-cycle pulses
            gnt           <= '0;
            done          <= '0;
            err           <= 1'b0;
            uart_transmit <= 1'b0;
            case (state)
                IDLE: begin
                    // A busy uart in IDLE means someone else is using it: hold off.
                    if (win_found && !uart_is_transmitting) begin
                        uart_tx_byte  <= win_byte;
                        uart_transmit <= 1'b1;
                        gnt           <= NREQ'(1) << win_idx;
                        last          <= win_idx;
                        busy          <= 1'b1;
                        state         <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    count <= '0;
                    state <= WAIT_START;
                end
                WAIT_START: begin
                    if (uart_is_transmitting) begin
                        state <= WAIT_END;
                    end else if (count == CNT_W'(START_TIMEOUT - 1)) begin
                        // uart never picked the byte up; give up without done
                        err   <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        count <= count + CNT_W'(1);
                    end
                end
                WAIT_END: begin
                    // The uart keeps is_transmitting high through its stop bits,
                    // so no extra inter-byte gap is needed here.
                    if (!uart_is_transmitting) begin
                        done  <= NREQ'(1) << last;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed testbench for uart_tx_arbiter: a 2-requester instance driven by a
// small uart model, plus a 4-requester instance driven by hand for wrap-around.
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    // 2-requester instance
    logic [1:0]  req_a = '0;
    logic [15:0] byte_a = '0;
    logic [1:0]  gnt_a, done_a;
    logic        err_a, busy_a, tx_a;
    logic [7:0]  txb_a;
    logic        istx_a;

    // 4-requester instance
    logic [3:0]  req_b = '0;
    logic [31:0] byte_b = '0;
    logic [3:0]  gnt_b, done_b;
    logic        err_b, busy_b, tx_b;
    logic [7:0]  txb_b;
    logic        istx_b = 1'b0;

    // uart model control: 0 = normal, 1 = never starts, 2 = driven by force_val
    logic [1:0]  mode = 2'd0;
    logic        force_val = 1'b0;
    logic        is_tx0 = 1'b0;
    logic [3:0]  tx_cnt = '0;

    int errors = 0;
    int checks = 0;

    uart_tx_arbiter #(.NREQ(2), .START_TIMEOUT(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .req(req_a), .req_byte(byte_a),
        .gnt(gnt_a), .done(done_a), .err(err_a), .busy(busy_a),
        .uart_transmit(tx_a), .uart_tx_byte(txb_a),
        .uart_is_transmitting(istx_a)
    );

    uart_tx_arbiter #(.NREQ(4), .START_TIMEOUT(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .req(req_b), .req_byte(byte_b),
        .gnt(gnt_b), .done(done_b), .err(err_b), .busy(busy_b),
        .uart_transmit(tx_b), .uart_tx_byte(txb_b),
        .uart_is_transmitting(istx_b)
    );

    always #5 clk = ~clk;

    // uart model: is_transmitting rises the cycle after transmit, stays up 3 cycles
    always @(posedge clk) begin
        if (mode != 2'd0) begin
            is_tx0 <= 1'b0;
            tx_cnt <= '0;
        end else if (tx_a) begin
            is_tx0 <= 1'b1;
            tx_cnt <= 4'd3;
        end else if (tx_cnt != 0) begin
            tx_cnt <= tx_cnt - 4'd1;
            if (tx_cnt == 4'd1) is_tx0 <= 1'b0;
        end
    end

    assign istx_a = (mode == 2'd2) ? force_val : is_tx0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_a = '0;
        req_b = '0;
        mode = 2'd0;
        force_val = 1'b0;
        istx_b = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic wait_gnt_a(input int budget, output int cycles, output bit seen);
        seen = 1'b0;
        cycles = 0;
        while (!seen && cycles < budget) begin
            if (gnt_a != 0) seen = 1'b1;
            else begin
                step();
                cycles++;
            end
        end
    endtask

    task automatic wait_done_a(input int budget, output int cycles, output bit seen);
        seen = 1'b0;
        cycles = 0;
        while (!seen && cycles < budget) begin
            if (done_a != 0) seen = 1'b1;
            else begin
                step();
                cycles++;
            end
        end
    endtask

    // hand-driven uart for instance b: start one cycle after launch, end next cycle
    task automatic complete_b();
        step();
        istx_b = 1'b1;
        step();
        istx_b = 1'b0;
        step();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({gnt_a, done_a, err_a, busy_a, tx_a} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctrl_a: got %b want 0", {gnt_a, done_a, err_a, busy_a, tx_a});
        end
        checks++;
        if (txb_a !== 8'h00) begin
            errors++;
            $display("FAIL reset_byte_a: got %h want 00", txb_a);
        end
        checks++;
        if ({gnt_b, done_b, err_b, busy_b, tx_b, txb_b} !== 19'b0) begin
            errors++;
            $display("FAIL reset_b: got %h want 0", {gnt_b, done_b, err_b, busy_b, tx_b, txb_b});
        end
    endtask

    task automatic test_single();
        int cyc;
        bit seen;
        do_reset();
        byte_a = 16'h00A5;
        req_a = 2'b01;
        step();
        checks++;
        if ({gnt_a, tx_a, busy_a} !== 4'b0111) begin
            errors++;
            $display("FAIL single_grant: got gnt=%b tx=%b busy=%b want 01 1 1", gnt_a, tx_a, busy_a);
        end
        checks++;
        if (txb_a !== 8'hA5) begin
            errors++;
            $display("FAIL single_byte: got %h want a5", txb_a);
        end
        req_a = 2'b00;
        step();
        checks++;
        if ({gnt_a, tx_a} !== 3'b000) begin
            errors++;
            $display("FAIL single_pulse: got gnt=%b tx=%b want 00 0", gnt_a, tx_a);
        end
        wait_done_a(20, cyc, seen);
        checks++;
        if (!seen || done_a !== 2'b01 || cyc != 4) begin
            errors++;
            $display("FAIL single_done: got done=%b after %0d want 01 after 4", done_a, cyc);
        end
        checks++;
        if ({busy_a, err_a, txb_a} !== {2'b00, 8'hA5}) begin
            errors++;
            $display("FAIL single_idle: got busy=%b err=%b byte=%h want 0 0 a5", busy_a, err_a, txb_a);
        end
        step();
        checks++;
        if ({done_a, busy_a} !== 3'b000) begin
            errors++;
            $display("FAIL single_after: got done=%b busy=%b want 00 0", done_a, busy_a);
        end
    endtask

    task automatic test_round_robin();
        int cyc;
        bit seen;
        logic [1:0] exp_g;
        logic [7:0] exp_b;
        do_reset();
        byte_a = 16'h2211;
        req_a = 2'b11;
        for (int n = 0; n < 4; n++) begin
            exp_g = (n % 2 == 0) ? 2'b01 : 2'b10;
            exp_b = (n % 2 == 0) ? 8'h11 : 8'h22;
            wait_gnt_a(30, cyc, seen);
            checks++;
            if (!seen || gnt_a !== exp_g || txb_a !== exp_b) begin
                errors++;
                $display("FAIL rr_grant%0d: got gnt=%b byte=%h want %b %h", n, gnt_a, txb_a, exp_g, exp_b);
            end
            if (n > 0) begin
                checks++;
                if (cyc != 0) begin
                    errors++;
                    $display("FAIL rr_on_done%0d: got grant %0d cycles after done want 0", n, cyc);
                end
            end
            step();
            wait_done_a(20, cyc, seen);
            checks++;
            if (!seen || done_a !== exp_g) begin
                errors++;
                $display("FAIL rr_done%0d: got %b want %b", n, done_a, exp_g);
            end
            step();
        end
        req_a = 2'b00;
    endtask

    task automatic test_timeout();
        int cyc;
        bit seen;
        bit err_seen;
        bit done_seen;
        do_reset();
        mode = 2'd1;
        byte_a = 16'h005A;
        req_a = 2'b01;
        step();
        checks++;
        if (gnt_a !== 2'b01) begin
            errors++;
            $display("FAIL to_grant: got %b want 01", gnt_a);
        end
        req_a = 2'b00;
        step();
        cyc = 0;
        err_seen = 1'b0;
        done_seen = 1'b0;
        while (!err_seen && cyc < 40) begin
            step();
            cyc++;
            if (done_a != 0) done_seen = 1'b1;
            if (err_a) err_seen = 1'b1;
        end
        checks++;
        if (!err_seen || cyc != 16) begin
            errors++;
            $display("FAIL to_err: got err=%b after %0d want 1 after 16", err_seen, cyc);
        end
        checks++;
        if (done_seen || busy_a !== 1'b0) begin
            errors++;
            $display("FAIL to_state: got done_seen=%b busy=%b want 0 0", done_seen, busy_a);
        end
        step();
        checks++;
        if (err_a !== 1'b0) begin
            errors++;
            $display("FAIL to_pulse: got %b want 0", err_a);
        end
        mode = 2'd0;
        byte_a = 16'h7700;
        req_a = 2'b10;
        wait_gnt_a(10, cyc, seen);
        checks++;
        if (!seen || gnt_a !== 2'b10 || txb_a !== 8'h77) begin
            errors++;
            $display("FAIL to_next: got gnt=%b byte=%h want 10 77", gnt_a, txb_a);
        end
        req_a = 2'b00;
        step();
        wait_done_a(20, cyc, seen);
        checks++;
        if (!seen || done_a !== 2'b10) begin
            errors++;
            $display("FAIL to_next_done: got %b want 10", done_a);
        end
    endtask

    task automatic test_foreign();
        int cyc;
        bit seen;
        bit any_gnt;
        do_reset();
        mode = 2'd2;
        force_val = 1'b1;
        byte_a = 16'hC300;
        req_a = 2'b10;
        any_gnt = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (gnt_a != 0) any_gnt = 1'b1;
        end
        checks++;
        if (any_gnt) begin
            errors++;
            $display("FAIL foreign_hold: got grant while uart busy want none");
        end
        force_val = 1'b0;
        step();
        checks++;
        if (gnt_a !== 2'b10 || txb_a !== 8'hC3) begin
            errors++;
            $display("FAIL foreign_grant: got gnt=%b byte=%h want 10 c3", gnt_a, txb_a);
        end
        mode = 2'd0;
        req_a = 2'b00;
        step();
        wait_done_a(20, cyc, seen);
        checks++;
        if (!seen || done_a !== 2'b10) begin
            errors++;
            $display("FAIL foreign_done: got %b want 10", done_a);
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        bit seen;
        bit done_seen;
        do_reset();
        byte_a = 16'h0033;
        req_a = 2'b01;
        step();
        req_a = 2'b00;
        step();
        step();
        step();
        checks++;
        if (busy_a !== 1'b1) begin
            errors++;
            $display("FAIL mid_busy: got %b want 1", busy_a);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({gnt_a, done_a, err_a, busy_a, tx_a, txb_a} !== 15'b0) begin
            errors++;
            $display("FAIL mid_async: got %h want 0", {gnt_a, done_a, err_a, busy_a, tx_a, txb_a});
        end
        #2;
        rst_n = 1'b1;
        done_seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (done_a != 0) done_seen = 1'b1;
        end
        checks++;
        if (done_seen) begin
            errors++;
            $display("FAIL mid_no_done: got done for aborted byte want none");
        end
        // both request: req[0] must win because the pointer is back at NREQ-1
        byte_a = 16'h4433;
        req_a = 2'b11;
        wait_gnt_a(10, cyc, seen);
        checks++;
        if (!seen || gnt_a !== 2'b01 || txb_a !== 8'h33) begin
            errors++;
            $display("FAIL mid_regrant: got gnt=%b byte=%h want 01 33", gnt_a, txb_a);
        end
        req_a = 2'b10;
        step();
        wait_done_a(20, cyc, seen);
        step();
        wait_gnt_a(10, cyc, seen);
        checks++;
        if (!seen || gnt_a !== 2'b10 || txb_a !== 8'h44) begin
            errors++;
            $display("FAIL mid_req1: got gnt=%b byte=%h want 10 44", gnt_a, txb_a);
        end
        req_a = 2'b00;
        step();
        wait_done_a(20, cyc, seen);
    endtask

    task automatic test_wrap();
        do_reset();
        byte_b = 32'h44332211;
        req_b = 4'b1000;
        step();
        checks++;
        if (gnt_b !== 4'b1000 || txb_b !== 8'h44) begin
            errors++;
            $display("FAIL wrap_first: got gnt=%b byte=%h want 1000 44", gnt_b, txb_b);
        end
        req_b = 4'b0000;
        complete_b();
        checks++;
        if (done_b !== 4'b1000) begin
            errors++;
            $display("FAIL wrap_done3: got %b want 1000", done_b);
        end
        req_b = 4'b1001;
        step();
        checks++;
        if (gnt_b !== 4'b0001 || txb_b !== 8'h11) begin
            errors++;
            $display("FAIL wrap_to0: got gnt=%b byte=%h want 0001 11", gnt_b, txb_b);
        end
        req_b = 4'b1000;
        complete_b();
        checks++;
        if (done_b !== 4'b0001) begin
            errors++;
            $display("FAIL wrap_done0: got %b want 0001", done_b);
        end
        step();
        checks++;
        if (gnt_b !== 4'b1000 || txb_b !== 8'h44) begin
            errors++;
            $display("FAIL wrap_to3: got gnt=%b byte=%h want 1000 44", gnt_b, txb_b);
        end
        req_b = 4'b0000;
        complete_b();
        checks++;
        if (done_b !== 4'b1000 || err_b !== 1'b0) begin
            errors++;
            $display("FAIL wrap_done3b: got done=%b err=%b want 1000 0", done_b, err_b);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_foreign();
        test_reset_mid();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
